mix_columns_seq: RTL and testbench

Sequencer that runs a full 128-bit AES state through a single shared `MixColumns` column unit, one 32-bit column per cycle, in forward or inverse mode. It sits between the round datapath (SubBytes/ShiftRows upstream, AddRoundKey downstream) and time-multiplexes one combinational `MixColumns` instance instead of four. Both sides use valid/ready handshakes. The input block is captured on acceptance, so upstream may change `in_state` immediately afterwards.

---
 rtl/aes_mc_pkg.sv | 28 ++
 rtl/mix_columns_seq_mixcolumns.sv | 59 +++++
 rtl/mix_columns_seq.sv | 118 +++++++++++
 tb/tb_mix_columns_seq.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_mc_pkg.sv
// Shared AES round-datapath types plus column helpers for the 128-bit state.
package aes_mc_pkg;

   localparam int unsigned AES_COLS = 4;

   typedef logic [7:0]   aes_byte_t;
   typedef logic [31:0]  aes_col_t;
   typedef logic [127:0] aes_state_t;

   typedef enum logic [1:0] {MC_IDLE, MC_RUN, MC_DONE} mc_fsm_t;

   // Column idx occupies bits [127-32*idx -: 32]; column 0 is the MSW.
   function automatic aes_col_t get_col(input aes_state_t s, input logic [1:0] idx);
      int unsigned sh;
      sh = (AES_COLS - 1 - 32'(idx)) * 32;
      return aes_col_t'(s >> sh);
   endfunction

   function automatic aes_state_t set_col(input aes_state_t s, input logic [1:0] idx,
                                          input aes_col_t c);
      int unsigned sh;
      aes_state_t  mask;
      sh   = (AES_COLS - 1 - 32'(idx)) * 32;
      mask = aes_state_t'(32'hFFFF_FFFF) << sh;
      return (s & ~mask) | (aes_state_t'(c) << sh);
   endfunction

endpackage

// File: rtl/mix_columns_seq_mixcolumns.sv
// Combinational single-column MixColumns: forward (a0..a3) and inverse (c0..c3).
module MixColumns
   import aes_mc_pkg::*;
(
   input  logic [7:0] b0,
   input  logic [7:0] b1,
   input  logic [7:0] b2,
   input  logic [7:0] b3,
   output logic [7:0] a0,
   output logic [7:0] a1,
   output logic [7:0] a2,
   output logic [7:0] a3,
   output logic [7:0] c0,
   output logic [7:0] c1,
   output logic [7:0] c2,
   output logic [7:0] c3
);

   function automatic aes_byte_t xt(input aes_byte_t x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic aes_byte_t m2(input aes_byte_t x);
      return xt(x);
   endfunction

   function automatic aes_byte_t m3(input aes_byte_t x);
      return xt(x) ^ x;
   endfunction

   function automatic aes_byte_t m9(input aes_byte_t x);
      return xt(xt(xt(x))) ^ x;
   endfunction

   function automatic aes_byte_t m11(input aes_byte_t x);
      return xt(xt(xt(x))) ^ xt(x) ^ x;
   endfunction

   function automatic aes_byte_t m13(input aes_byte_t x);
      return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
   endfunction

   function automatic aes_byte_t m14(input aes_byte_t x);
      return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
   endfunction

   // Circulant matrix products for both directions
   always_comb begin
      a0 = m2(b0)  ^ m3(b1)  ^ b2      ^ b3;
      a1 = b0      ^ m2(b1)  ^ m3(b2)  ^ b3;
      a2 = b0      ^ b1      ^ m2(b2)  ^ m3(b3);
      a3 = m3(b0)  ^ b1      ^ b2      ^ m2(b3);
      c0 = m14(b0) ^ m11(b1) ^ m13(b2) ^ m9(b3);
      c1 = m9(b0)  ^ m14(b1) ^ m11(b2) ^ m13(b3);
      c2 = m13(b0) ^ m9(b1)  ^ m14(b2) ^ m11(b3);
      c3 = m11(b0) ^ m13(b1) ^ m9(b2)  ^ m14(b3);
   end

endmodule

// File: rtl/mix_columns_seq.sv
// Runs a 128-bit AES state through one shared MixColumns unit, one column per cycle.
module mix_columns_seq
   import aes_mc_pkg::*;
#(
   parameter int REG_COL  = 0,
   parameter int NUM_COLS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_inv,
   input  logic [127:0] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         out_inv,
   output logic         busy
);

   if (NUM_COLS != AES_COLS) begin : g_bad_cols
      $error("mix_columns_seq: NUM_COLS must equal AES_COLS");
   end

   mc_fsm_t    r_state, w_next;
   logic [1:0] r_col;
   aes_state_t r_work, r_res;
   logic       r_mode;
   aes_col_t   r_pipe;
   logic       r_last;

   logic       w_in_ready, w_accept, w_run_end;
   aes_col_t   w_b, w_mc;
   logic [7:0] w_a0, w_a1, w_a2, w_a3, w_c0, w_c1, w_c2, w_c3;

   assign w_b = get_col(r_work, r_col);

   MixColumns u_mc (
      .b0(w_b[31:24]), .b1(w_b[23:16]), .b2(w_b[15:8]), .b3(w_b[7:0]),
      .a0(w_a0), .a1(w_a1), .a2(w_a2), .a3(w_a3),
      .c0(w_c0), .c1(w_c1), .c2(w_c2), .c3(w_c3)
   );

   // Direction select for the shared column unit
   always_comb begin
      w_mc = r_mode ? {w_c0, w_c1, w_c2, w_c3} : {w_a0, w_a1, w_a2, w_a3};
   end

   // With the column register, r_last marks the flush cycle after column 3
   always_comb begin
      w_run_end = (REG_COL == 0) ? (r_col == 2'd3) : r_last;
   end

   // Next-state and input handshake
   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      case (r_state)
         MC_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) w_next = MC_RUN;
         end
         MC_RUN: begin
            if (w_run_end) w_next = MC_DONE;
         end
         MC_DONE: begin
            if (out_ready) begin
               w_in_ready = 1'b1;
               w_next     = in_valid ? MC_RUN : MC_IDLE;
            end
         end
         default: w_next = MC_IDLE;
      endcase
   end

   assign in_ready = w_in_ready & ~rst;
   assign w_accept = in_valid & in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= MC_IDLE;
      else     r_state <= w_next;
   end

   // Capture, column walk and result write-back. With REG_COL the write
   // lags by one cycle and targets col-1, so the wrapped col=0 flush
   // cycle (r_last) lands on column 3.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col  <= '0;
         r_work <= '0;
         r_res  <= '0;
         r_mode <= 1'b0;
         r_pipe <= '0;
         r_last <= 1'b0;
      end else if (w_accept) begin
         r_work <= in_state;
         r_mode <= in_inv;
         r_col  <= '0;
         r_last <= 1'b0;
      end else if (r_state == MC_RUN) begin
         r_col <= r_col + 2'd1;
         if (REG_COL == 0) begin
            r_res <= set_col(r_res, r_col, w_mc);
         end else begin
            r_pipe <= w_mc;
            r_last <= (r_col == 2'd3);
            if ((r_col != 2'd0) || r_last) r_res <= set_col(r_res, r_col - 2'd1, r_pipe);
         end
      end
   end

   assign out_valid = (r_state == MC_DONE);
   assign busy      = (r_state == MC_RUN);
   assign out_state = r_res;
   assign out_inv   = r_mode;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq (REG_COL=0 and REG_COL=1 instances).
module tb_mix_columns_seq;

   localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] B2B_IN   = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
   localparam logic [127:0] B2B_OUT  = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, in_valid, in_ready, in_inv, out_valid, out_ready, out_inv, busy;
   logic [127:0] in_state, out_state;
   logic         rst1, in_valid1, in_ready1, in_inv1, out_valid1, out_ready1, out_inv1, busy1;
   logic [127:0] in_state1, out_state1;

   mix_columns_seq #(.REG_COL(0), .NUM_COLS(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
      .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
      .out_state(out_state), .out_inv(out_inv), .busy(busy)
   );

   mix_columns_seq #(.REG_COL(1), .NUM_COLS(4)) dut1 (
      .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_ready(in_ready1), .in_inv(in_inv1),
      .in_state(in_state1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_state(out_state1), .out_inv(out_inv1), .busy(busy1)
   );

   typedef struct packed {
      logic [127:0] st;
      logic         inv;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference GF(2^8) multiply by shift-and-add
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Full-state reference MixColumns as matrix-vector products
   function automatic logic [127:0] mc_model(input logic [127:0] s, input logic inv);
      logic [7:0]   base [4];
      logic [127:0] r = '0;
      logic [7:0]   acc;
      if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++)
               acc ^= gmul(base[(k - row + 4) % 4], s[127 - 32*c - 8*k -: 8]);
            r[127 - 32*c - 8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic exp_t mk_exp(input logic [127:0] st, input logic inv);
      exp_t e;
      e.st  = st;
      e.inv = inv;
      return e;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic test_reset();
      rst = 1'b1; rst1 = 1'b1;
      in_valid = 1'b1; in_inv = 1'b1; in_state = '1; out_ready = 1'b1;
      in_valid1 = 1'b0; in_inv1 = 1'b0; in_state1 = '0; out_ready1 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (out_state !== '0) begin n_err++; $display("FAIL reset_out_state: got %h want 0", out_state); end
      n_cmp++; if (out_inv !== 1'b0) begin n_err++; $display("FAIL reset_out_inv: got %b want 0", out_inv); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_regcol: got %b want 0", out_valid1); end
      rst = 1'b0; rst1 = 1'b0; in_valid = 1'b0; in_inv = 1'b0; in_state = '0;
      @(posedge clk); #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
   endtask

   // One block on dut0 with out_ready high; checks the 4-cycle latency.
   task automatic run_single(input logic [127:0] st, input logic inv, input logic [127:0] exp_st);
      bit   got = 1'b0;
      exp_t e;
      in_state = st; in_inv = inv; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_accept: in_ready got %b want 1", in_ready); end
      sb_q.push_back(mk_exp(exp_st, inv));
      @(posedge clk); #1;
      in_valid = 1'b0; in_state = rnd128(); in_inv = ~inv;
      for (int unsigned k = 0; k < 8 && !got; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         n_cmp++; if (out_valid !== (k == 4)) begin n_err++; $display("FAIL single_latency: cycle %0d out_valid got %b want %b", k, out_valid, (k == 4)); end
         n_cmp++; if (busy !== (k < 4)) begin n_err++; $display("FAIL single_busy: cycle %0d busy got %b want %b", k, busy, (k < 4)); end
         if (out_valid === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            got = 1'b1;
            n_cmp++; if (out_state !== e.st) begin n_err++; $display("FAIL single_state: got %h want %h", out_state, e.st); end
            n_cmp++; if (out_inv !== e.inv) begin n_err++; $display("FAIL single_inv: got %b want %b", out_inv, e.inv); end
         end
      end
      if (!got) begin n_cmp++; n_err++; sb_q.delete(); $display("FAIL single_timeout: no out_valid within 8 cycles want 1"); end
   endtask

   task automatic test_forward();
      run_single(FIPS_IN, 1'b0, FIPS_OUT);
   endtask

   task automatic test_inverse();
      run_single(FIPS_OUT, 1'b1, FIPS_IN);
   endtask

   task automatic test_back_to_back();
      logic [127:0] sts [4];
      logic         invs [4];
      exp_t         exps [4];
      exp_t         e;
      int unsigned  sent = 0, rcvd = 0, cyc = 0, last_acc = 0;
      bit           have_acc = 1'b0;
      sts[0] = B2B_IN;   invs[0] = 1'b0; exps[0] = mk_exp(B2B_OUT, 1'b0);
      sts[1] = FIPS_IN;  invs[1] = 1'b0; exps[1] = mk_exp(FIPS_OUT, 1'b0);
      sts[2] = rnd128(); invs[2] = 1'b1; exps[2] = mk_exp(mc_model(sts[2], 1'b1), 1'b1);
      sts[3] = rnd128(); invs[3] = 1'b0; exps[3] = mk_exp(mc_model(sts[3], 1'b0), 1'b0);
      out_ready = 1'b1;
      while (rcvd < 4 && cyc < 60) begin
         in_valid = (sent < 4);
         in_state = sts[(sent < 4) ? sent : 0];
         in_inv   = invs[(sent < 4) ? sent : 0];
         #1;
         if (in_valid && in_ready) begin
            if (have_acc) begin
               n_cmp++; if ((cyc - last_acc) != 5) begin n_err++; $display("FAIL b2b_interval: got %0d want 5", cyc - last_acc); end
            end
            have_acc = 1'b1; last_acc = cyc;
            sb_q.push_back(exps[sent]);
            sent++;
         end
         @(posedge clk); #1;
         cyc++;
         if (out_valid === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rcvd++;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_in_done: got %b want 1", in_ready); end
            n_cmp++; if (out_state !== e.st) begin n_err++; $display("FAIL b2b_state: got %h want %h", out_state, e.st); end
            n_cmp++; if (out_inv !== e.inv) begin n_err++; $display("FAIL b2b_inv: got %b want %b", out_inv, e.inv); end
         end
      end
      if (rcvd < 4) begin n_cmp++; n_err++; sb_q.delete(); $display("FAIL b2b_timeout: received %0d want 4", rcvd); end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [127:0] st1, st2;
      exp_t         e;
      st1 = rnd128(); st2 = rnd128();
      out_ready = 1'b0; in_valid = 1'b1; in_state = st1; in_inv = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_accept: in_ready got %b want 1", in_ready); end
      sb_q.push_back(mk_exp(mc_model(st1, 1'b0), 1'b0));
      @(posedge clk); #1;
      in_state = st2; in_inv = 1'b1;
      for (int unsigned k = 0; k < 10 && out_valid !== 1'b1; k++) begin @(posedge clk); #1; end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_reach_done: out_valid got %b want 1", out_valid); end
      for (int unsigned k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: cycle %0d got %b want 1", k, out_valid); end
         n_cmp++; if (out_state !== sb_q[0].st) begin n_err++; $display("FAIL bp_hold_state: cycle %0d got %h want %h", k, out_state, sb_q[0].st); end
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_in_ready: cycle %0d got %b want 0", k, in_ready); end
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
      e = sb_q.pop_front();
      n_cmp++; if (out_state !== e.st) begin n_err++; $display("FAIL bp_state1: got %h want %h", out_state, e.st); end
      sb_q.push_back(mk_exp(mc_model(st2, 1'b1), 1'b1));
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_release_run: busy got %b want 1", busy); end
      in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
      for (int unsigned k = 0; k < 8 && out_valid !== 1'b1; k++) begin @(posedge clk); #1; end
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      #1;
      e = sb_q.pop_front();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_done2: out_valid got %b want 1", out_valid); end
      n_cmp++; if (out_state !== e.st) begin n_err++; $display("FAIL bp_state2: got %h want %h", out_state, e.st); end
      n_cmp++; if (out_inv !== e.inv) begin n_err++; $display("FAIL bp_inv2: got %b want %b", out_inv, e.inv); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_release_idle: valid/busy/ready got %b%b%b want 001", out_valid, busy, in_ready);
      end
   endtask

   task automatic test_reset_midrun();
      int unsigned spurious = 0;
      in_valid = 1'b1; in_state = rnd128(); in_inv = 1'b0; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_accept: in_ready got %b want 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1; in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_state !== '0) begin n_err++; $display("FAIL rst_out_state: got %h want 0", out_state); end
      rst = 1'b0; in_valid = 1'b0;
      for (int unsigned k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) spurious++;
      end
      n_cmp++; if (spurious != 0) begin n_err++; $display("FAIL rst_no_partial: out_valid cycles got %0d want 0", spurious); end
      run_single(FIPS_IN, 1'b0, FIPS_OUT);
   endtask

   task automatic test_regcol();
      bit   got = 1'b0;
      exp_t e;
      in_state1 = FIPS_IN; in_inv1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b1;
      #1;
      n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL regcol_accept: in_ready got %b want 1", in_ready1); end
      sb_q.push_back(mk_exp(FIPS_OUT, 1'b0));
      @(posedge clk); #1;
      in_valid1 = 1'b0; in_state1 = rnd128(); in_inv1 = 1'b1;
      for (int unsigned k = 0; k < 9 && !got; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         n_cmp++; if (out_valid1 !== (k == 5)) begin n_err++; $display("FAIL regcol_latency: cycle %0d out_valid got %b want %b", k, out_valid1, (k == 5)); end
         n_cmp++; if (busy1 !== (k < 5)) begin n_err++; $display("FAIL regcol_busy: cycle %0d busy got %b want %b", k, busy1, (k < 5)); end
         if (out_valid1 === 1'b1 && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            got = 1'b1;
            n_cmp++; if (out_state1 !== e.st) begin n_err++; $display("FAIL regcol_state: got %h want %h", out_state1, e.st); end
            n_cmp++; if (out_inv1 !== e.inv) begin n_err++; $display("FAIL regcol_inv: got %b want %b", out_inv1, e.inv); end
         end
      end
      if (!got) begin n_cmp++; n_err++; sb_q.delete(); $display("FAIL regcol_timeout: no out_valid within 9 cycles want 1"); end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_inverse();
      test_back_to_back();
      test_backpressure();
      test_reset_midrun();
      test_regcol();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
